mdu_iter: RTL and testbench

Iterative multiply/divide unit for the EX stage, sitting beside the combinational ALU. It takes the same A/B operands and a 4-bit op code. It computes signed/unsigned 32x32 products and quotients/remainders over multiple cycles into the HI/LO registers, and reports busy so the hazard unit can stall mfhi/mflo/mult/div. It also handles mthi/mtlo writes.

---
 rtl/mdu_iter.sv | 163 ++++++++++++++++
 tb/tb_mdu_iter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit for the EX stage.
// One radix-2 step per cycle. MULT/MULTU use a 64-bit shift-add and DIV/DIVU
// use a restoring shift-subtract. Signed ops run on magnitudes, and the sign
// is fixed up in a final cycle. busy is high for ITER+1 cycles per mult/div.
// Ports:
//   clk, reset    rising-edge clock, async active-low reset
//   start, MDUop  request strobe and op (0 MULT,1 MULTU,2 DIV,3 DIVU,4 MTHI,5 MTLO)
//   A, B          operands (rs, rt)
//   busy          mult/div in flight
//   HI, LO        result registers
module mdu_iter #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       MDUop,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    // Multiply: {product_hi, multiplier/product_lo}
    // Divide:   {remainder, dividend/quotient}
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opb;     // |multiplicand| or |divisor|
    logic               r_div;
    logic               r_sgn_q;   // product / quotient sign
    logic               r_sgn_r;   // remainder sign (dividend's sign)
    logic               r_dz;      // divide by zero: suppress the write-back
    logic               r_busy;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_madd;
    logic [WIDTH:0]     w_dsh;
    logic [WIDTH+1:0]   w_dsub;
    logic [2*WIDTH-1:0] w_step;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign busy = r_busy;
    assign HI   = r_hi;
    assign LO   = r_lo;

    assign w_signed = (MDUop == 4'd0) || (MDUop == 4'd2);
    assign w_a_neg  = w_signed & A[WIDTH-1];
    assign w_b_neg  = w_signed & B[WIDTH-1];
    assign w_abs_a  = w_a_neg ? -A : A;
    assign w_abs_b  = w_b_neg ? -B : B;

    always_comb begin
        // Multiply step: conditionally add the multiplicand into the high half,
        // then shift the whole accumulator right and keep the carry.
        w_madd = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
        // Divide step: shift the next dividend bit into the remainder, then
        // trial-subtract. The top bit of w_dsub is the borrow.
        w_dsh  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_dsub = {1'b0, w_dsh} - {2'b00, r_opb};
        w_step = r_acc;
        if (r_div) begin
            if (!w_dsub[WIDTH+1])
                w_step = {w_dsub[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            else
                w_step = {w_dsh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
        end else begin
            w_step = {w_madd, r_acc[WIDTH-1:1]};
        end
    end

    assign w_prod = r_sgn_q ? -r_acc : r_acc;
    assign w_quo  = r_sgn_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_sgn_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_opb   <= '0;
            r_div   <= 1'b0;
            r_sgn_q <= 1'b0;
            r_sgn_r <= 1'b0;
            r_dz    <= 1'b0;
            r_busy  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        case (MDUop)
                            4'd0, 4'd1: begin
                                r_acc   <= {{WIDTH{1'b0}}, w_abs_b};
                                r_opb   <= w_abs_a;
                                r_div   <= 1'b0;
                                r_sgn_q <= w_a_neg ^ w_b_neg;
                                r_sgn_r <= 1'b0;
                                r_dz    <= 1'b0;
                                r_cnt   <= '0;
                                r_busy  <= 1'b1;
                                r_state <= S_RUN;
                            end
                            4'd2, 4'd3: begin
                                r_acc   <= {{WIDTH{1'b0}}, w_abs_a};
                                r_opb   <= w_abs_b;
                                r_div   <= 1'b1;
                                r_sgn_q <= w_a_neg ^ w_b_neg;
                                r_sgn_r <= w_a_neg;
                                r_dz    <= (B == '0);
                                r_cnt   <= '0;
                                r_busy  <= 1'b1;
                                r_state <= S_RUN;
                            end
                            4'd4:    r_hi <= A;
                            4'd5:    r_lo <= A;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(ITER - 1))
                        r_state <= S_FIX;
                end
                S_FIX: begin
                    if (r_div) begin
                        if (!r_dz) begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Testbench for mdu_iter. Expected HI:LO values go into a scoreboard queue when
// an op is issued. They are popped and compared when busy drops.
module tb_mdu_iter;

    localparam logic [3:0] OP_MULT = 4'd0, OP_MULTU = 4'd1, OP_DIV = 4'd2,
                           OP_DIVU = 4'd3, OP_MTHI = 4'd4, OP_MTLO = 4'd5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  MDUop = 4'd0;
    logic [31:0] A = '0, B = '0;
    logic        busy;
    logic [31:0] HI, LO;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_v;
    int cyc;

    mdu_iter #(.WIDTH(32), .ITER(32)) dut (
        .clk(clk), .reset(reset), .start(start), .MDUop(MDUop),
        .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    // Drive a one-cycle start, which is sampled at the next rising edge.
    // On return the time is 1 unit past that edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; MDUop = op; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0; A = $urandom; B = $urandom;
    endtask

    // Count the busy-high cycles after an accepted op. The wait is bounded.
    task automatic wait_idle(output int n);
        n = busy ? 1 : 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            if (busy) n++;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({busy, HI, LO} !== 65'd0) begin
            n_fail++;
            $display("FAIL reset: busy=%b HI=%h LO=%h exp all zero", busy, HI, LO);
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mult;
        exp_q.push_back(64'hFFFFFFFF_FFFFFFFD);
        issue(OP_MULT, 32'hFFFFFFFF, 32'd3);
        wait_idle(cyc);
        exp_v = exp_q.pop_front();
        n_tests++;
        if ({HI, LO} !== exp_v) begin n_fail++; $display("FAIL mult: HI:LO=%h exp %h", {HI, LO}, exp_v); end
        n_tests++;
        if (cyc !== 33) begin n_fail++; $display("FAIL mult_busy: cycles=%0d exp 33", cyc); end

        exp_q.push_back(64'h00000002_FFFFFFFD);
        issue(OP_MULTU, 32'hFFFFFFFF, 32'd3);
        wait_idle(cyc);
        exp_v = exp_q.pop_front();
        n_tests++;
        if ({HI, LO} !== exp_v) begin n_fail++; $display("FAIL multu: HI:LO=%h exp %h", {HI, LO}, exp_v); end
    endtask

    task automatic test_div;
        logic [3:0]  ops[3] = '{OP_DIV, OP_DIVU, OP_DIV};
        logic [31:0] as[3]  = '{32'hFFFFFFF9, 32'd7, 32'h80000000};
        logic [31:0] bs[3]  = '{32'd2, 32'd2, 32'hFFFFFFFF};
        logic [63:0] ex[3]  = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000001_00000003,
                                64'h00000000_80000000};
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(ex[i]);
            issue(ops[i], as[i], bs[i]);
            wait_idle(cyc);
            exp_v = exp_q.pop_front();
            n_tests++;
            if ({HI, LO} !== exp_v) begin
                n_fail++;
                $display("FAIL div%0d: HI:LO=%h exp %h", i, {HI, LO}, exp_v);
            end
            n_tests++;
            if (cyc !== 33) begin n_fail++; $display("FAIL div%0d_busy: cycles=%0d exp 33", i, cyc); end
        end
    endtask

    task automatic test_mt_divzero;
        issue(OP_MTHI, 32'h1234, 32'd0);
        n_tests++;
        if (busy !== 1'b0 || HI !== 32'h1234) begin
            n_fail++; $display("FAIL mthi: busy=%b HI=%h exp 0/00001234", busy, HI);
        end
        issue(OP_MTLO, 32'h5678, 32'd0);
        n_tests++;
        if (busy !== 1'b0 || LO !== 32'h5678) begin
            n_fail++; $display("FAIL mtlo: busy=%b LO=%h exp 0/00005678", busy, LO);
        end
        // An undefined op must leave everything alone.
        issue(4'd9, 32'hAAAA5555, 32'd1);
        n_tests++;
        if ({busy, HI, LO} !== {1'b0, 32'h1234, 32'h5678}) begin
            n_fail++; $display("FAIL undef_op: busy=%b HI=%h LO=%h", busy, HI, LO);
        end
        exp_q.push_back({32'h1234, 32'h5678});
        issue(OP_DIV, 32'd77, 32'd0);
        wait_idle(cyc);
        exp_v = exp_q.pop_front();
        n_tests++;
        if ({HI, LO} !== exp_v) begin n_fail++; $display("FAIL divzero: HI:LO=%h exp %h", {HI, LO}, exp_v); end
        n_tests++;
        if (cyc !== 33) begin n_fail++; $display("FAIL divzero_busy: cycles=%0d exp 33", cyc); end
    endtask

    task automatic test_busy_ignore;
        exp_q.push_back(64'd30);
        issue(OP_MULTU, 32'd5, 32'd6);
        cyc = 1;
        while (busy && cyc < 100) begin
            if (cyc == 10) begin start = 1'b1; MDUop = OP_MTHI; A = 32'hDEAD; end
            else if (cyc == 11) begin start = 1'b1; MDUop = OP_DIVU; A = 32'd9; B = 32'd3; end
            else start = 1'b0;
            @(posedge clk); #1;
            if (busy) cyc++;
        end
        start = 1'b0;
        exp_v = exp_q.pop_front();
        n_tests++;
        if ({HI, LO} !== exp_v) begin n_fail++; $display("FAIL busy_ignore: HI:LO=%h exp %h", {HI, LO}, exp_v); end
        n_tests++;
        if (cyc !== 33) begin n_fail++; $display("FAIL busy_ignore_cycles: cycles=%0d exp 33", cyc); end
        // The ignored DIVU must not have started once busy dropped.
        @(posedge clk); #1;
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_ignore_restart: busy=%b exp 0", busy); end
    endtask

    task automatic test_reset_mid;
        issue(OP_MULT, 32'h10000, 32'h10000);
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        n_tests++;
        if ({busy, HI, LO} !== 65'd0) begin
            n_fail++; $display("FAIL reset_mid: busy=%b HI=%h LO=%h exp all zero", busy, HI, LO);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(64'd6);
        issue(OP_MULTU, 32'd2, 32'd3);
        wait_idle(cyc);
        exp_v = exp_q.pop_front();
        n_tests++;
        if ({HI, LO} !== exp_v || cyc !== 33) begin
            n_fail++; $display("FAIL after_reset: HI:LO=%h cycles=%0d exp %h/33", {HI, LO}, cyc, exp_v);
        end
    endtask

    task automatic test_back_to_back;
        exp_q.push_back(64'h00000002_0000000E);
        exp_q.push_back(64'hFFFFFFFE_00000001);
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_idle(cyc);
        exp_v = exp_q.pop_front();
        n_tests++;
        if ({HI, LO} !== exp_v) begin n_fail++; $display("FAIL b2b_first: HI:LO=%h exp %h", {HI, LO}, exp_v); end
        // Issue in the same cycle busy fell.
        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: busy=%b exp 1", busy); end
        wait_idle(cyc);
        exp_v = exp_q.pop_front();
        n_tests++;
        if ({HI, LO} !== exp_v || cyc !== 33) begin
            n_fail++; $display("FAIL b2b_second: HI:LO=%h cycles=%0d exp %h/33", {HI, LO}, cyc, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mt_divzero();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
